// File: rtl/input_buffer_ctrl_if.sv
// Bundles the pixel input stream, buffer port and PE tap stream of input_buffer_ctrl.
// stall_cycles exists only when IBC_PERF_CNT_EN is defined.
interface input_buffer_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 6
);
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  buf_write_en;
    logic [ADDR_W-1:0]     buf_write_addr;
    logic [DATA_WIDTH-1:0] buf_data_in;
    logic [ADDR_W-1:0]     buf_read_addr;
    logic [DATA_WIDTH-1:0] buf_data_out;
    logic                  px_valid;
    logic                  px_ready;
    logic [DATA_WIDTH-1:0] px_data;
    logic                  px_last_tap;
    logic                  frame_done;
    logic                  busy;
`ifdef IBC_PERF_CNT_EN
    logic [15:0]           stall_cycles;
`endif

    // master is the sequencer; slave is the surrounding source, buffer and PE
    modport master (
        input  start, in_valid, in_data, buf_data_out, px_ready,
        output in_ready, buf_write_en, buf_write_addr, buf_data_in,
               buf_read_addr, px_valid, px_data, px_last_tap, frame_done, busy
`ifdef IBC_PERF_CNT_EN
        , output stall_cycles
`endif
    );

    modport slave (
        output start, in_valid, in_data, buf_data_out, px_ready,
        input  in_ready, buf_write_en, buf_write_addr, buf_data_in,
               buf_read_addr, px_valid, px_data, px_last_tap, frame_done, busy
`ifdef IBC_PERF_CNT_EN
        , input stall_cycles
`endif
    );
endinterface

// File: rtl/input_buffer_ctrl.sv
// Fills the input buffer with one raster frame, then streams every KERNEL x KERNEL window to the PE.
// Define IBC_PERF_CNT_EN to add the saturating stall_cycles counter.
module input_buffer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 64,
    parameter int IMG_W      = 8,
    parameter int KERNEL     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input_buffer_ctrl_if.master bus
);
    localparam int IMG_H  = SIZE / IMG_W;
    localparam int ADDR_W = $clog2(SIZE);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  K_MAX       = CNT_W'(KERNEL - 1);
    localparam logic [CNT_W-1:0]  OUT_COL_MAX = CNT_W'(IMG_W - KERNEL);
    localparam logic [CNT_W-1:0]  OUT_ROW_MAX = CNT_W'(IMG_H - KERNEL);
    localparam logic [CNT_W-1:0]  IMG_W_C     = CNT_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(SIZE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_SCAN, ST_DONE} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  wr_addr_reg, wr_addr_next;
    logic [ADDR_W-1:0]  rd_addr_reg, rd_addr_next;
    logic [CNT_W-1:0]   r_reg, r_next;
    logic [CNT_W-1:0]   c_reg, c_next;
    logic [CNT_W-1:0]   kr_reg, kr_next;
    logic [CNT_W-1:0]   kc_reg, kc_next;
    logic               in_ready;
    logic               px_valid;
    logic               last_tap;
    logic               last_window;

    assign last_tap    = (kr_reg == K_MAX) && (kc_reg == K_MAX);
    assign last_window = (r_reg == OUT_ROW_MAX) && (c_reg == OUT_COL_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        wr_addr_next = wr_addr_reg;
        rd_addr_next = rd_addr_reg;
        r_next       = r_reg;
        c_next       = c_reg;
        kr_next      = kr_reg;
        kc_next      = kc_reg;
        in_ready     = 1'b0;
        px_valid     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next   = ST_FILL;
                    wr_addr_next = '0;
                    rd_addr_next = '0;
                    r_next       = '0;
                    c_next       = '0;
                    kr_next      = '0;
                    kc_next      = '0;
                end
            end
            ST_FILL: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    // the pointer parks on the last address instead of wrapping
                    if (wr_addr_reg == LAST_ADDR) begin
                        state_next = ST_SCAN;
                    end else begin
                        wr_addr_next = wr_addr_reg + 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                px_valid = 1'b1;
                if (bus.px_ready) begin
                    if (kc_reg != K_MAX) begin
                        kc_next = kc_reg + 1'b1;
                    end else begin
                        kc_next = '0;
                        if (kr_reg != K_MAX) begin
                            kr_next = kr_reg + 1'b1;
                        end else begin
                            kr_next = '0;
                            if (c_reg != OUT_COL_MAX) begin
                                c_next = c_reg + 1'b1;
                            end else begin
                                c_next = '0;
                                r_next = (r_reg != OUT_ROW_MAX) ? r_reg + 1'b1 : '0;
                            end
                        end
                    end
                    // after the final tap every counter wraps, leaving the address at 0
                    rd_addr_next = ADDR_W'((r_next + kr_next) * IMG_W_C + c_next + kc_next);
                    if (last_tap && last_window) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_reg <= '0;
            rd_addr_reg <= '0;
            r_reg       <= '0;
            c_reg       <= '0;
            kr_reg      <= '0;
            kc_reg      <= '0;
        end else begin
            wr_addr_reg <= wr_addr_next;
            rd_addr_reg <= rd_addr_next;
            r_reg       <= r_next;
            c_reg       <= c_next;
            kr_reg      <= kr_next;
            kc_reg      <= kc_next;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.buf_write_en   = bus.in_valid & in_ready;
    assign bus.buf_write_addr = wr_addr_reg;
    assign bus.buf_data_in    = bus.in_data;
    assign bus.buf_read_addr  = rd_addr_reg;
    assign bus.px_valid       = px_valid;
    assign bus.px_data        = bus.buf_data_out;
    assign bus.px_last_tap    = px_valid & last_tap;
    assign bus.frame_done     = (state_reg == ST_DONE);
    assign bus.busy           = (state_reg != ST_IDLE);

`ifdef IBC_PERF_CNT_EN
    logic [15:0] stall_cnt_reg, stall_cnt_next;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if ((state_reg == ST_IDLE) && bus.start) begin
            stall_cnt_next = '0;
        end else if (px_valid && !bus.px_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign bus.stall_cycles = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Directed bench: a KERNEL=3 and a KERNEL=1 controller, each with a behavioural buffer loaded with data=addr.
`timescale 1ns/1ps
module tb_input_buffer_ctrl;
    localparam int DW    = 8;
    localparam int SIZE  = 64;
    localparam int IMG_W = 8;
    localparam int AW    = 6;
    localparam int TAPS3 = 324;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    input_buffer_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) a_if ();
    input_buffer_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) b_if ();

    input_buffer_ctrl #(.DATA_WIDTH(DW), .SIZE(SIZE), .IMG_W(IMG_W), .KERNEL(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if.master));
    input_buffer_ctrl #(.DATA_WIDTH(DW), .SIZE(SIZE), .IMG_W(IMG_W), .KERNEL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if.master));

    logic [DW-1:0] mem_a [SIZE];
    logic [DW-1:0] mem_b [SIZE];
    always @(posedge clk) begin
        if (a_if.buf_write_en) mem_a[a_if.buf_write_addr] <= a_if.buf_data_in;
        if (b_if.buf_write_en) mem_b[b_if.buf_write_addr] <= b_if.buf_data_in;
    end
    assign a_if.buf_data_out = mem_a[a_if.buf_read_addr];
    assign b_if.buf_data_out = mem_b[b_if.buf_read_addr];

    int checks = 0;
    int failures = 0;
    int obs_addr [TAPS3];
    int first_win [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_in_ready"}, a_if.in_ready, 0);
        check({tag, "_wen"}, a_if.buf_write_en, 0);
        check({tag, "_waddr"}, a_if.buf_write_addr, 0);
        check({tag, "_raddr"}, a_if.buf_read_addr, 0);
        check({tag, "_px_valid"}, a_if.px_valid, 0);
        check({tag, "_last_tap"}, a_if.px_last_tap, 0);
        check({tag, "_frame_done"}, a_if.frame_done, 0);
        check({tag, "_busy"}, a_if.busy, 0);
`ifdef IBC_PERF_CNT_EN
        check({tag, "_stall_cycles"}, a_if.stall_cycles, 0);
`endif
    endtask

    task automatic start_a();
        a_if.start = 1'b1;
        #1;
        check("start_idle_busy", a_if.busy, 0);
        @(negedge clk);
        a_if.start = 1'b0;
        check("start_busy", a_if.busy, 1);
        check("start_in_ready", a_if.in_ready, 1);
`ifdef IBC_PERF_CNT_EN
        check("start_stall_clr", a_if.stall_cycles, 0);
`endif
    endtask

    task automatic fill_a(input bit rnd);
        int beat = 0;
        int cyc = 0;
        while (beat < SIZE && cyc < 1000) begin
            a_if.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            a_if.in_data  = 8'(beat);
            #1;
            check("fill_in_ready", a_if.in_ready, 1);
            check("fill_wen", a_if.buf_write_en, a_if.in_valid);
            if (a_if.in_valid) begin
                check("fill_waddr", a_if.buf_write_addr, beat);
                check("fill_wdata", a_if.buf_data_in, beat);
            end
            @(negedge clk);
            if (a_if.in_valid) beat++;
            cyc++;
        end
        check("fill_beats", beat, SIZE);
        a_if.in_valid = 1'b0;
        #1;
        check("scan_entry_px_valid", a_if.px_valid, 1);
        check("scan_entry_in_ready", a_if.in_ready, 0);
        check("scan_entry_raddr", a_if.buf_read_addr, 0);
    endtask

    // Consumes taps in the expected order; optional stall, start/in_valid poke and early exit
    task automatic scan_a(input int stall_at, input int stall_len, input int abort_at,
                          input int poke_at, output int taps);
        int idx = 0;
        int exp;
        taps = 0;
        for (int r = 0; r <= 5; r++)
            for (int c = 0; c <= 5; c++)
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++) begin
                        exp = (r + kr) * IMG_W + c + kc;
                        if (idx == abort_at) begin
                            taps = idx;
                            return;
                        end
                        if (idx == stall_at) begin
                            repeat (stall_len) begin
                                a_if.px_ready = 1'b0;
                                #1;
                                check("stall_raddr", a_if.buf_read_addr, exp);
                                check("stall_data", a_if.px_data, exp);
                                check("stall_valid", a_if.px_valid, 1);
                                @(negedge clk);
                            end
                        end
                        if (idx == poke_at) begin
                            a_if.start = 1'b1;
                            a_if.in_valid = 1'b1;
                        end
                        a_if.px_ready = 1'b1;
                        #1;
                        obs_addr[idx] = int'(a_if.buf_read_addr);
                        check("tap_raddr", a_if.buf_read_addr, exp);
                        check("tap_data", a_if.px_data, exp);
                        check("tap_valid", a_if.px_valid, 1);
                        check("tap_last", a_if.px_last_tap, (kr == 2 && kc == 2) ? 1 : 0);
                        check("tap_frame_done", a_if.frame_done, 0);
                        if (idx == poke_at) begin
                            check("poke_wen", a_if.buf_write_en, 0);
                            check("poke_in_ready", a_if.in_ready, 0);
                        end
                        @(negedge clk);
                        a_if.start = 1'b0;
                        a_if.in_valid = 1'b0;
                        idx++;
                    end
        taps = idx;
        check("done_frame_done", a_if.frame_done, 1);
        check("done_px_valid", a_if.px_valid, 0);
        check("done_busy", a_if.busy, 1);
        @(negedge clk);
        check("idle_frame_done", a_if.frame_done, 0);
        check("idle_busy", a_if.busy, 0);
        check("idle_raddr", a_if.buf_read_addr, 0);
    endtask

    initial begin
        int taps;
        a_if.start = 1'b0; a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.px_ready = 1'b0;
        b_if.start = 1'b0; b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.px_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_a("reset");
        check("reset_b_busy", b_if.busy, 0);
        check("reset_b_raddr", b_if.buf_read_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        a_if.in_valid = 1'b1;
        #1;
        check("idle_in_valid_ready", a_if.in_ready, 0);
        check("idle_in_valid_wen", a_if.buf_write_en, 0);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        check("idle_in_valid_busy", a_if.busy, 0);
        $display("step reset: checks=%0d", checks);

        // Plain frame with an always-ready PE
        start_a();
        fill_a(1'b0);
        scan_a(-1, 0, -1, -1, taps);
        check("frame1_taps", taps, TAPS3);
        for (int i = 0; i < 9; i++) check("first_window", obs_addr[i], first_win[i]);
        check("last_tap_addr", obs_addr[TAPS3-1], 63);
`ifdef IBC_PERF_CNT_EN
        check("frame1_stall_cycles", a_if.stall_cycles, 0);
`endif
        $display("step frame1: taps=%0d checks=%0d", taps, checks);

        // Sparse input beats, 5-cycle stall at tap 10, start/in_valid poked at tap 50
        start_a();
        fill_a(1'b1);
        scan_a(10, 5, -1, 50, taps);
        check("frame2_taps", taps, TAPS3);
`ifdef IBC_PERF_CNT_EN
        check("frame2_stall_cycles", a_if.stall_cycles, 5);
`endif
        $display("step frame2: taps=%0d checks=%0d", taps, checks);

        // Abort by reset at tap 100, then a complete frame
        start_a();
        fill_a(1'b0);
        scan_a(-1, 0, 100, -1, taps);
        check("abort_at_tap", taps, 100);
        rst_n = 1'b0;
        #1;
        check_reset_a("abort");
        check("abort_px_data", a_if.px_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_a();
        fill_a(1'b0);
        scan_a(-1, 0, -1, -1, taps);
        check("frame3_taps", taps, TAPS3);
        $display("step abort+frame3: taps=%0d checks=%0d", taps, checks);

        // KERNEL=1: every pixel is a complete window
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            b_if.in_valid = 1'b1;
            b_if.in_data = 8'(i);
            #1;
            check("k1_waddr", b_if.buf_write_addr, i);
            @(negedge clk);
        end
        b_if.in_valid = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            b_if.px_ready = 1'b1;
            #1;
            check("k1_raddr", b_if.buf_read_addr, i);
            check("k1_data", b_if.px_data, i);
            check("k1_valid", b_if.px_valid, 1);
            check("k1_last", b_if.px_last_tap, 1);
            @(negedge clk);
        end
        check("k1_frame_done", b_if.frame_done, 1);
        @(negedge clk);
        check("k1_idle_busy", b_if.busy, 0);
        $display("step kernel1: taps=%0d checks=%0d", SIZE, checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
